// File: rtl/prog_loader.sv
// Boot-time program loader: framed byte stream -> RAM write port, checksum gate on cpu_run.
// Define LOADER_CLEAR_EN to zero the whole RAM after reset/restart before accepting a frame.
module prog_loader #(
  parameter logic [7:0]  BASE_ADDR = 8'h00,
  parameter logic [15:0] TIMEOUT   = 16'd1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       restart,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_data,
  output logic       ram_we,
  output logic       cpu_run,
  output logic       load_busy,
  output logic       load_err,
  output logic [7:0] byte_count
);

`ifdef LOADER_CLEAR_EN
  typedef enum logic [2:0] {S_IDLE, S_DATA, S_CHECK, S_RUN, S_ERR, S_CLEAR} state_t;
  localparam state_t RST_STATE = S_CLEAR;
  logic [7:0] clr_idx;
`else
  typedef enum logic [2:0] {S_IDLE, S_DATA, S_CHECK, S_RUN, S_ERR} state_t;
  localparam state_t RST_STATE = S_IDLE;
`endif

  state_t      state, state_d;
  logic [7:0]  acc, len_q, chk_sum, last_idx;
  logic [15:0] tcnt;
  logic        hs, expired;

  // LEN=0 encodes 256 bytes; the 8-bit wrap of len_q-1 handles that for free
  assign last_idx = len_q - 8'd1;
  assign chk_sum  = acc + in_data;
  assign expired  = (tcnt == TIMEOUT);
  assign hs       = in_valid & in_ready;

  always_comb begin
    state_d   = state;
    in_ready  = (state == S_IDLE) || (state == S_DATA) || (state == S_CHECK);
    load_busy = (state == S_DATA) || (state == S_CHECK);
    case (state)
      S_IDLE:  if (hs) state_d = S_DATA;
      S_DATA: begin
        if (hs) begin
          if (byte_count == last_idx) state_d = S_CHECK;
        end else if (expired) state_d = S_ERR;
      end
      S_CHECK: begin
        if (hs) state_d = (chk_sum == 8'h00) ? S_RUN : S_ERR;
        else if (expired) state_d = S_ERR;
      end
`ifdef LOADER_CLEAR_EN
      S_CLEAR: begin
        load_busy = 1'b1;
        if (clr_idx == 8'hFF) state_d = S_IDLE;
      end
`endif
      default: ;
    endcase
    // restart beats everything, including a same-cycle handshake
    if (restart) state_d = RST_STATE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RST_STATE;
      ram_we     <= 1'b0;
      ram_addr   <= BASE_ADDR;
      ram_data   <= 8'h00;
      cpu_run    <= 1'b0;
      load_err   <= 1'b0;
      byte_count <= 8'h00;
      acc        <= 8'h00;
      len_q      <= 8'h00;
      tcnt       <= 16'd0;
`ifdef LOADER_CLEAR_EN
      clr_idx    <= 8'h00;
`endif
    end else begin
      state    <= state_d;
      ram_we   <= 1'b0;
      cpu_run  <= (state == S_RUN);
      load_err <= (state == S_ERR);
      if (restart) begin
        cpu_run    <= 1'b0;
        load_err   <= 1'b0;
        byte_count <= 8'h00;
        acc        <= 8'h00;
        tcnt       <= 16'd0;
`ifdef LOADER_CLEAR_EN
        clr_idx    <= 8'h00;
`endif
      end else begin
        case (state)
          S_IDLE: if (hs) begin
            len_q      <= in_data;
            acc        <= in_data;
            byte_count <= 8'h00;
            tcnt       <= 16'd0;
          end
          S_DATA, S_CHECK: begin
            if (hs) begin
              tcnt <= 16'd0;
              if (state == S_DATA) begin
                acc        <= chk_sum;
                ram_we     <= 1'b1;
                ram_addr   <= BASE_ADDR + byte_count;
                ram_data   <= in_data;
                byte_count <= byte_count + 8'd1;
              end
            end else begin
              tcnt <= tcnt + 16'd1;
            end
          end
`ifdef LOADER_CLEAR_EN
          S_CLEAR: begin
            ram_we   <= 1'b1;
            ram_addr <= BASE_ADDR + clr_idx;
            ram_data <= 8'h00;
            clr_idx  <= clr_idx + 8'd1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected RAM writes queued by stimulus, popped by a monitor.
module tb_prog_loader;
  localparam logic [7:0]  BASE = 8'hFE;
  localparam logic [15:0] TO   = 16'd10;

  logic       clk = 0, rst_n = 0, in_valid = 0, restart = 0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, ram_we, cpu_run, load_busy, load_err;
  logic [7:0] ram_addr, ram_data, byte_count;

  int total = 0, bad = 0;
  logic [15:0] exp_q[$];

  prog_loader #(.BASE_ADDR(BASE), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .restart(restart), .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .cpu_run(cpu_run), .load_busy(load_busy), .load_err(load_err), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  // Monitor: every ram_we pulse must match the head of the expected-write queue
  always @(negedge clk) begin
    if (rst_n && ram_we) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL ram_write unexpected: got addr=%h data=%h, required none", ram_addr, ram_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({ram_addr, ram_data} !== e) begin
          bad++;
          $display("FAIL ram_write: got addr=%h data=%h, required addr=%h data=%h",
                   ram_addr, ram_data, e[15:8], e[7:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic push_clear();
`ifdef LOADER_CLEAR_EN
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      a = BASE + 8'(i);
      exp_q.push_back({a, 8'h00});
    end
`endif
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 600) begin @(negedge clk); t++; end
    if (!in_ready) chk("wait_ready_timeout", {15'd0, in_ready}, 16'd1);
  endtask

  // Called at a negedge; returns at the negedge after the byte transfers
  task automatic send(input logic [7:0] b);
    in_data = b; in_valid = 1'b1;
    wait_ready();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_payload(input logic [7:0] idx, input logic [7:0] b);
    logic [7:0] a;
    a = BASE + idx;
    exp_q.push_back({a, b});
    send(b);
  endtask

  task automatic do_restart();
    push_clear();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    wait_ready();
    chk("restart_cpu_run", {15'd0, cpu_run}, 16'd0);
    chk("restart_load_err", {15'd0, load_err}, 16'd0);
    chk("restart_byte_count", {8'd0, byte_count}, 16'd0);
  endtask

  task automatic frame_a(input logic [7:0] chk_byte);
    send(8'h02);
    send_payload(8'd0, 8'hE0);
    send_payload(8'd1, 8'h04);
    send(chk_byte);
  endtask

  initial begin
    int clr_cycles = 0;
    // Reset state
    #2;
    @(negedge clk);
    chk("rst_ram_we", {15'd0, ram_we}, 16'd0);
    chk("rst_ram_addr", {8'd0, ram_addr}, {8'd0, BASE});
    chk("rst_cpu_run", {15'd0, cpu_run}, 16'd0);
    chk("rst_load_err", {15'd0, load_err}, 16'd0);
    chk("rst_byte_count", {8'd0, byte_count}, 16'd0);
`ifdef LOADER_CLEAR_EN
    chk("rst_in_ready", {15'd0, in_ready}, 16'd0);
`else
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
    chk("rst_load_busy", {15'd0, load_busy}, 16'd0);
`endif
    push_clear();
    rst_n = 1'b1;
    while (!in_ready && clr_cycles < 600) begin @(negedge clk); clr_cycles++; end
`ifdef LOADER_CLEAR_EN
    chk("clear_cycles", clr_cycles[15:0], 16'd256);
`else
    chk("clear_cycles", clr_cycles[15:0], 16'd0);
`endif

    // Good frame 02,E0,04,1A
    frame_a(8'h1A);
    chk("a_cpu_run_early", {15'd0, cpu_run}, 16'd0);
    @(negedge clk);
    chk("a_cpu_run", {15'd0, cpu_run}, 16'd1);
    chk("a_load_err", {15'd0, load_err}, 16'd0);
    chk("a_load_busy", {15'd0, load_busy}, 16'd0);
    chk("a_byte_count", {8'd0, byte_count}, 16'd2);
    chk("a_in_ready", {15'd0, in_ready}, 16'd0);
    do_restart();

    // Bad checksum
    frame_a(8'h1B);
    @(negedge clk);
    chk("b_cpu_run", {15'd0, cpu_run}, 16'd0);
    chk("b_load_err", {15'd0, load_err}, 16'd1);
    do_restart();

    // Address wrap past 8'hFF
    send(8'h03);
    send_payload(8'd0, 8'h11);
    send_payload(8'd1, 8'h22);
    send_payload(8'd2, 8'h33);
    send(8'h97);
    @(negedge clk);
    chk("wrap_cpu_run", {15'd0, cpu_run}, 16'd1);
    do_restart();

    // LEN=0 -> 256 payload bytes
    send(8'h00);
    for (int i = 0; i < 256; i++) begin
      send_payload(8'(i), 8'h01);
      if (i == 0) chk("len0_byte_count_1", {8'd0, byte_count}, 16'd1);
    end
    chk("len0_busy_check", {15'd0, load_busy}, 16'd1);
    send(8'h00);
    @(negedge clk);
    chk("len0_byte_count_wrap", {8'd0, byte_count}, 16'd0);
    chk("len0_cpu_run", {15'd0, cpu_run}, 16'd1);
    do_restart();

    // Handshake arriving exactly at timeout expiry wins
    send(8'h02);
    send_payload(8'd0, 8'hE0);
    repeat (10) @(negedge clk);
    chk("edge_busy", {15'd0, load_busy}, 16'd1);
    send_payload(8'd1, 8'h04);
    send(8'h1A);
    @(negedge clk);
    chk("edge_cpu_run", {15'd0, cpu_run}, 16'd1);
    chk("edge_load_err", {15'd0, load_err}, 16'd0);
    do_restart();

    // Timeout abort
    send(8'h02);
    send_payload(8'd0, 8'hE0);
    repeat (5) @(negedge clk);
    chk("to_not_yet", {15'd0, load_err}, 16'd0);
    begin
      int t = 0;
      while (!load_err && t < 20) begin @(negedge clk); t++; end
    end
    chk("to_load_err", {15'd0, load_err}, 16'd1);
    chk("to_in_ready", {15'd0, in_ready}, 16'd0);
    do_restart();
    chk("to_restart_in_ready", {15'd0, in_ready}, 16'd1);

    // Restart together with the second payload handshake
    send(8'h02);
    send_payload(8'd0, 8'hE0);
    push_clear();
    in_data = 8'h04; in_valid = 1'b1; restart = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; restart = 1'b0;
    chk("rhs_byte_count", {8'd0, byte_count}, 16'd0);
    wait_ready();
    frame_a(8'h1A);
    @(negedge clk);
    chk("rhs_cpu_run", {15'd0, cpu_run}, 16'd1);

    repeat (3) @(negedge clk);
    chk("pending_writes", exp_q.size() > 65535 ? 16'hFFFF : 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
